// File: rtl/assoc_cache.sv
// assoc_cache: set-associative, write-back / write-allocate cache controller.
// One request in flight. Lines move to and from memory as whole lines.
// Replacement uses the lowest invalid way first, then a per-set round-robin pointer.
// Optional build macro CACHE_STATS_EN adds saturating 32-bit hit_count / miss_count outputs.
module assoc_cache #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 access,
  input  logic [ADDRESS_WIDTH-1:0]             address,
  input  logic                                 op,
  input  logic                                 byteOP,
  input  logic [WORD_WIDTH-1:0]                data_in,
  output logic                                 ready,
  output logic [WORD_WIDTH-1:0]                data_out,
  output logic                                 done,
  output logic                                 hit,
  output logic                                 miss,
  output logic                                 mem_req,
  output logic                                 mem_we,
  output logic [ADDRESS_WIDTH-1:0]             mem_addr,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                                 mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                          hit_count,
  output logic [31:0]                          miss_count
`endif
);

  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int BOFF_BITS      = $clog2(BYTES_PER_WORD);
  localparam int WOFF_BITS      = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS       = $clog2(NUM_SETS);
  localparam int LINE_OFF_BITS  = BOFF_BITS + WOFF_BITS;
  localparam int TAG_LSB        = LINE_OFF_BITS + IDX_BITS;
  localparam int TAG_W          = ADDRESS_WIDTH - TAG_LSB;
  localparam int LINE_W         = WORD_WIDTH * WORDS_PER_LINE;

  // Field widths never collapse to zero; the masks keep degenerate fields at 0.
  localparam int BOFF_W = (BOFF_BITS > 0) ? BOFF_BITS : 1;
  localparam int WOFF_W = (WOFF_BITS > 0) ? WOFF_BITS : 1;
  localparam int IDX_W  = (IDX_BITS  > 0) ? IDX_BITS  : 1;
  localparam int WAY_W  = (NUM_WAYS  > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [BOFF_W-1:0] BOFF_MASK = BOFF_W'(BYTES_PER_WORD - 1);
  localparam logic [WOFF_W-1:0] WOFF_MASK = WOFF_W'(WORDS_PER_LINE - 1);
  localparam logic [IDX_W-1:0]  IDX_MASK  = IDX_W'(NUM_SETS - 1);
  localparam logic [WAY_W-1:0]  WAY_MASK  = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_t;

  state_t r_state;
  state_t w_next;

  // Registered request
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_op;
  logic                     r_byte;
  logic [WORD_WIDTH-1:0]    r_wdata;
  logic [WAY_W-1:0]         r_victim;

  // Per-set state
  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
  logic [WAY_W-1:0]    r_rr    [NUM_SETS];
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   r_data  [NUM_SETS][NUM_WAYS];

  // Decoded fields of the registered address
  logic [BOFF_W-1:0] w_boff;
  logic [WOFF_W-1:0] w_woff;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;

  assign w_boff = BOFF_W'(r_addr) & BOFF_MASK;
  assign w_woff = WOFF_W'(r_addr >> BOFF_BITS) & WOFF_MASK;
  assign w_idx  = IDX_W'(r_addr >> LINE_OFF_BITS) & IDX_MASK;
  assign w_tag  = TAG_W'(r_addr >> TAG_LSB);

  // Read the addressed word, or the addressed byte zero-extended.
  function automatic logic [WORD_WIDTH-1:0] f_read(
    input logic [LINE_W-1:0] line,
    input logic [WOFF_W-1:0] woff,
    input logic [BOFF_W-1:0] boff,
    input logic              is_byte
  );
    logic [WORD_WIDTH-1:0] word;
    logic [WORD_WIDTH-1:0] res;
    word = line[woff*WORD_WIDTH +: WORD_WIDTH];
    res  = '0;
    if (is_byte) res[7:0] = word[boff*8 +: 8];
    else         res      = word;
    return res;
  endfunction

  // Overlay write data on a line: the whole word, or only the addressed byte lane.
  function automatic logic [LINE_W-1:0] f_merge(
    input logic [LINE_W-1:0]     line,
    input logic [WOFF_W-1:0]     woff,
    input logic [BOFF_W-1:0]     boff,
    input logic                  is_byte,
    input logic [WORD_WIDTH-1:0] wdata
  );
    logic [LINE_W-1:0] res;
    res = line;
    for (int b = 0; b < WORDS_PER_LINE * BYTES_PER_WORD; b++) begin
      if ((b / BYTES_PER_WORD) == int'(woff) &&
          (!is_byte || (b % BYTES_PER_WORD) == int'(boff))) begin
        res[b*8 +: 8] = is_byte ? wdata[7:0] : wdata[(b % BYTES_PER_WORD)*8 +: 8];
      end
    end
    return res;
  endfunction

  // Line-aligned byte address built from a tag and set index.
  function automatic logic [ADDRESS_WIDTH-1:0] f_line_addr(
    input logic [TAG_W-1:0] tag,
    input logic [IDX_W-1:0] idx
  );
    return (ADDRESS_WIDTH'(tag) << TAG_LSB) | (ADDRESS_WIDTH'(idx) << LINE_OFF_BITS);
  endfunction

  // Tag match and lowest invalid way within the addressed set
  logic             w_hit_any;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_inv_any;
  logic [WAY_W-1:0] w_inv_way;

  // Scan ways high to low so the lowest matching index is the one kept.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    w_inv_any = 1'b0;
    w_inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_inv_any = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  logic [WAY_W-1:0]      w_victim;
  logic                  w_victim_wb;
  logic [WAY_W-1:0]      w_rd_way;
  logic [WORD_WIDTH-1:0] w_rd_value;

  assign w_victim    = w_inv_any ? w_inv_way : r_rr[w_idx];
  assign w_victim_wb = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
  // A hit reads its own way; a completed refill reads the way just installed.
  assign w_rd_way    = (r_state == S_LOOKUP) ? w_hit_way : r_victim;
  assign w_rd_value  = f_read(r_data[w_idx][w_rd_way], w_woff, w_boff, r_byte);

  // Next-state and output decode; every output idles at 0 except ready in IDLE.
  always_comb begin
    w_next    = r_state;
    ready     = 1'b0;
    done      = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    data_out  = '0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (access) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit_any) begin
          done     = 1'b1;
          hit      = 1'b1;
          data_out = w_rd_value;
          w_next   = S_IDLE;
        end else begin
          miss   = 1'b1;
          w_next = w_victim_wb ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = f_line_addr(r_tag[w_idx][r_victim], w_idx);
        mem_wdata = r_data[w_idx][r_victim];
        if (mem_ready) w_next = S_REFILL;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = f_line_addr(w_tag, w_idx);
        if (mem_ready) w_next = S_RESPOND;
      end
      S_RESPOND: begin
        done     = 1'b1;
        data_out = w_rd_value;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM register, request capture, and valid/dirty/round-robin bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_op     <= 1'b0;
      r_byte   <= 1'b0;
      r_wdata  <= '0;
      r_victim <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (access) begin
            r_addr  <= address;
            r_op    <= op;
            r_byte  <= byteOP;
            r_wdata <= data_in;
          end
        end
        S_LOOKUP: begin
          if (w_hit_any) begin
            if (!r_op) r_dirty[w_idx][w_hit_way] <= 1'b1;
          end else begin
            r_victim <= w_victim;
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            // A write miss merges its data during install, so the line starts dirty.
            r_dirty[w_idx][r_victim] <= ~r_op;
            if (r_valid[w_idx][r_victim]) begin
              r_rr[w_idx] <= (r_rr[w_idx] + WAY_W'(1)) & WAY_MASK;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line data and tags; meaningful only behind a valid bit.
  // NOTE: the data and tag arrays have no reset; clearing the valid bits is enough to hide stale contents.
  always_ff @(posedge clk) begin
    if (r_state == S_LOOKUP && w_hit_any && !r_op) begin
      r_data[w_idx][w_hit_way] <= f_merge(r_data[w_idx][w_hit_way], w_woff, w_boff, r_byte, r_wdata);
    end
    if (r_state == S_REFILL && mem_ready) begin
      r_tag[w_idx][r_victim]  <= w_tag;
      r_data[w_idx][r_victim] <= r_op ? mem_rdata
                                      : f_merge(mem_rdata, w_woff, w_boff, r_byte, r_wdata);
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating event counters for hit and miss pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (hit && (r_hit_count != 32'hFFFF_FFFF))   r_hit_count  <= r_hit_count + 32'd1;
      if (miss && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed scenarios followed by randomized traffic against a
// reference built from a flat word memory plus per-set replacement bookkeeping.
module tb_assoc_cache;

  localparam int SETS = 4;
  localparam int WAYS = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         access = 1'b0;
  logic [31:0]  address = '0;
  logic         op = 1'b0;
  logic         byteOP = 1'b0;
  logic [31:0]  data_in = '0;
  logic         ready;
  logic [31:0]  data_out;
  logic         done;
  logic         hit;
  logic         miss;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk       (clk),
    .reset     (reset),
    .access    (access),
    .address   (address),
    .op        (op),
    .byteOP    (byteOP),
    .data_in   (data_in),
    .ready     (ready),
    .data_out  (data_out),
    .done      (done),
    .hit       (hit),
    .miss      (miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing memory (what the cache talks to) and the program-visible memory.
  logic [31:0] dram     [int unsigned];
  logic [31:0] ref_word [int unsigned];

  function automatic logic [31:0] default_word(input int unsigned a);
    return 32'h5A00_0000 ^ a;
  endfunction

  function automatic logic [31:0] dram_rd(input int unsigned a);
    return dram.exists(a) ? dram[a] : default_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned a);
    return ref_word.exists(a) ? ref_word[a] : default_word(a);
  endfunction

  function automatic logic [127:0] ref_line(input int unsigned line_addr);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_rd(line_addr + 4*w);
    return l;
  endfunction

  // Memory responder: mem_ready on the third cycle of a held request.
  bit spurious_en = 1'b0;
  int mem_cnt = 0;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (reset) begin
      mem_cnt = 0;
    end else if (mem_req) begin
      mem_cnt++;
      if (mem_cnt == 3) begin
        mem_cnt = 0;
        mem_ready = 1'b1;
        if (mem_we) begin
          for (int w = 0; w < 4; w++) dram[mem_addr + 4*w] = mem_wdata[w*32 +: 32];
        end else begin
          for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = dram_rd(mem_addr + 4*w);
        end
      end
    end else begin
      mem_cnt = 0;
      if (spurious_en && $urandom_range(0, 3) == 0) begin
        mem_ready = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Replacement bookkeeping of the reference.
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  int          m_rr    [SETS];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  // One complete request: predict, issue, monitor, compare.
  task automatic do_txn(
    input  string        tag,
    input  bit           wr,
    input  bit           bop,
    input  logic [31:0]  a,
    input  logic [31:0]  d,
    output logic         o_hit,
    output logic [31:0]  o_data,
    output bit           o_wb,
    output logic [31:0]  o_wb_addr,
    output logic [127:0] o_wb_data,
    output logic [31:0]  o_rf_addr
  );
    int unsigned set, tg, wa, lane;
    int          v, guard, cyc, done_cyc, miss_n, ready_busy;
    bit          exp_hit, exp_wb, got_done, any_mem, rf_seen;
    logic [31:0]  exp_wb_addr, exp_rd, word;
    logic [127:0] exp_wb_data;

    set  = (a >> 4) & 3;
    tg   = a >> 6;
    wa   = a & ~32'h3;
    lane = a & 3;
    exp_hit = 1'b0;
    exp_wb  = 1'b0;
    exp_wb_addr = '0;
    exp_wb_data = '0;
    v = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!exp_hit && m_valid[set][w] && m_tag[set][w] == tg) begin
        exp_hit = 1'b1;
        v = w;
      end
    end
    if (!exp_hit) begin
      v = -1;
      for (int w = 0; w < WAYS; w++) if (v < 0 && !m_valid[set][w]) v = w;
      if (v < 0) begin
        v = m_rr[set];
        m_rr[set] = (m_rr[set] + 1) % WAYS;
        exp_wb = m_dirty[set][v];
        exp_wb_addr = (m_tag[set][v] << 6) | (set << 4);
        exp_wb_data = ref_line(exp_wb_addr);
      end
      m_valid[set][v] = 1'b1;
      m_tag[set][v]   = tg;
      m_dirty[set][v] = 1'b0;
    end
    word = ref_rd(wa);
    exp_rd = bop ? ((word >> (lane*8)) & 32'hFF) : word;
    if (wr) begin
      m_dirty[set][v] = 1'b1;
      if (bop) begin
        word[lane*8 +: 8] = d[7:0];
        ref_word[wa] = word;
      end else begin
        ref_word[wa] = d;
      end
    end

    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("%s.ready", tag), ready, 1'b1);
    access  = 1'b1;
    op      = wr ? 1'b0 : 1'b1;
    byteOP  = bop;
    address = a;
    data_in = d;
    @(posedge clk);

    cyc = 0; done_cyc = 0; miss_n = 0; ready_busy = 0;
    got_done = 1'b0; any_mem = 1'b0; rf_seen = 1'b0;
    o_hit = 1'b0; o_data = '0; o_wb = 1'b0; o_wb_addr = '0; o_wb_data = '0; o_rf_addr = '0;
    while (!got_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (miss)  miss_n++;
      if (ready) ready_busy++;
      if (mem_req) begin
        any_mem = 1'b1;
        if (mem_we && !o_wb) begin
          o_wb = 1'b1;
          o_wb_addr = mem_addr;
          o_wb_data = mem_wdata;
        end
        if (!mem_we && !rf_seen) begin
          rf_seen = 1'b1;
          o_rf_addr = mem_addr;
        end
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        o_hit    = hit;
        o_data   = data_out;
        access   = 1'b0;
      end else begin
        // Busy: request inputs must already be captured; extra requests must be ignored.
        access  = 1'($urandom_range(0, 1));
        address = $urandom;
        op      = 1'($urandom_range(0, 1));
        byteOP  = 1'($urandom_range(0, 1));
        data_in = $urandom;
      end
    end
    access = 1'b0;

    check($sformatf("%s.done", tag), got_done, 1'b1);
    check($sformatf("%s.hit", tag), o_hit, exp_hit);
    check($sformatf("%s.miss_pulses", tag), miss_n, exp_hit ? 0 : 1);
    check($sformatf("%s.ready_busy", tag), ready_busy, 0);
    if (exp_hit) begin
      check($sformatf("%s.hit_latency", tag), done_cyc, 1);
      check($sformatf("%s.hit_mem_req", tag), any_mem, 1'b0);
    end else begin
      check($sformatf("%s.writeback", tag), o_wb, exp_wb);
      if (exp_wb) begin
        check($sformatf("%s.wb_addr", tag), o_wb_addr, exp_wb_addr);
        check($sformatf("%s.wb_data", tag), o_wb_data, exp_wb_data);
      end
      check($sformatf("%s.refill", tag), rf_seen, 1'b1);
      check($sformatf("%s.rf_addr", tag), o_rf_addr, a & ~32'hF);
    end
    if (!wr) check($sformatf("%s.data", tag), o_data, exp_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         h;
    logic [31:0]  dout, wba, rfa;
    logic [127:0] wbd;
    bit           wb;
    bit           seen_refill;
    int           guard;

    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset.ready", ready, 1'b1);
    check("reset.done", done, 1'b0);
    check("reset.hit", hit, 1'b0);
    check("reset.miss", miss, 1'b0);
    check("reset.mem_req", mem_req, 1'b0);
    check("reset.mem_we", mem_we, 1'b0);
    check("reset.data_out", data_out, 32'h0);
    check("reset.mem_addr", mem_addr, 32'h0);

    // Cold read miss.
    do_txn("r047", 1'b0, 1'b0, 32'h04, 32'h0, h, dout, wb, wba, wbd, rfa);
    check("r047.const_data", dout, 32'h5A00_0004);
    check("r047.const_rf", rfa, 32'h0);
    check("r047.no_wb", wb, 1'b0);

    // Write hit then read hit.
    do_txn("r048w", 1'b1, 1'b0, 32'h04, 32'h0000_0011, h, dout, wb, wba, wbd, rfa);
    do_txn("r048r", 1'b0, 1'b0, 32'h04, 32'h0, h, dout, wb, wba, wbd, rfa);
    check("r048.const_data", dout, 32'h0000_0011);
    check("r048.const_hit", h, 1'b1);
`ifdef CACHE_STATS_EN
    check("r052.hit_count", hit_count, 32'd2);
    check("r052.miss_count", miss_count, 32'd1);
`endif

    // Byte write and byte/word reads.
    do_txn("r049bw", 1'b1, 1'b1, 32'h06, 32'hFFFF_FFAB, h, dout, wb, wba, wbd, rfa);
    do_txn("r049wr", 1'b0, 1'b0, 32'h04, 32'h0, h, dout, wb, wba, wbd, rfa);
    check("r049.word", dout, 32'h00AB_0011);
    do_txn("r049br", 1'b0, 1'b1, 32'h06, 32'h0, h, dout, wb, wba, wbd, rfa);
    check("r049.byte", dout, 32'h0000_00AB);

    // Fill set 0, then evict the dirty way 0.
    do_txn("r050a", 1'b0, 1'b0, 32'h44, 32'h0, h, dout, wb, wba, wbd, rfa);
    do_txn("r050b", 1'b0, 1'b0, 32'h84, 32'h0, h, dout, wb, wba, wbd, rfa);
    check("r050.wb", wb, 1'b1);
    check("r050.wb_addr", wba, 32'h00);
    check("r050.wb_word1", wbd[63:32], 32'h00AB_0011);
    check("r050.rf_addr", rfa, 32'h80);

    // Reset during the second REFILL cycle of a miss on 0x04.
    while (!ready) @(negedge clk);
    access = 1'b1; op = 1'b1; byteOP = 1'b0; address = 32'h04; data_in = '0;
    @(posedge clk);
    @(negedge clk);
    access = 1'b0;
    seen_refill = 1'b0;
    guard = 0;
    while (!seen_refill && guard < 20) begin
      if (mem_req && !mem_we) seen_refill = 1'b1;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    check("r051.refill_entered", seen_refill, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("r051.mem_req", mem_req, 1'b0);
    check("r051.ready", ready, 1'b1);
    check("r051.done", done, 1'b0);
    model_reset();
    ref_word = dram;
    do_txn("r051re", 1'b0, 1'b0, 32'h04, 32'h0, h, dout, wb, wba, wbd, rfa);
    check("r051.remiss", h, 1'b0);
    check("r051.redata", dout, 32'h00AB_0011);

    // Randomized traffic over a small address window to force conflicts.
    spurious_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      do_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 511)), $urandom, h, dout, wb, wba, wbd, rfa);
    end
    spurious_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
- REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, byte address width.
- REQ-002 The block SHALL have parameter WORD_WIDTH, default 32, data word width; multiple of 8.
- REQ-003 The block SHALL have parameter WORDS_PER_LINE, default 4, words per line; power of 2.
- REQ-004 The block SHALL have parameter NUM_SETS, default 4, sets; power of 2.
- REQ-005 The block SHALL have parameter NUM_WAYS, default 2, ways per set; power of 2, at least 1.
- REQ-006 The block SHALL run on one clock; reset is synchronous and active-high.
- REQ-007 clk  in  1  clock; all state updates on rising edge.
- REQ-008 reset  in  1  synchronous active-high reset.
- REQ-009 access  in  1  request valid.
- REQ-010 address  in  ADDRESS_WIDTH  byte address.
- REQ-011 op  in  1  0 = write, 1 = read.
- REQ-012 byteOP  in  1  1 = byte access, 0 = word access.
- REQ-013 data_in  in  WORD_WIDTH  write data; byte in bits [7:0] when byteOP=1.
- REQ-014 ready  out  1  idle, can accept a request.
- REQ-015 data_out  out  WORD_WIDTH  read data, valid while done=1.
- REQ-016 done  out  1  one-cycle completion pulse.
- REQ-017 hit  out  1  pulses with done when the request hit.
- REQ-018 miss  out  1  one-cycle pulse on miss detection.
- REQ-019 mem_req, mem_we  out  1 each  line transfer request and direction (1 = writeback).
- REQ-020 mem_addr  out  ADDRESS_WIDTH  line-aligned address.
- REQ-021 mem_wdata / mem_rdata  out / in  WORD_WIDTH*WORDS_PER_LINE  line data.
- REQ-022 mem_ready  in  1  one-cycle pulse; transfer complete; mem_rdata valid this cycle.

Function
- REQ-023 Address fields SHALL be, LSB to MSB: byte offset (log2(WORD_WIDTH/8) bits), word offset, set index, tag (remaining bits).
- REQ-024 A request SHALL be accepted when access=1 and ready=1.
- REQ-025 The block SHALL register address, op, byteOP and data_in on acceptance; these inputs may then change.
- REQ-026 The FSM SHALL have states IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- REQ-027 ready SHALL be 1 only in IDLE.
- REQ-028 Transitions:
  - IDLE to LOOKUP on acceptance.
  - LOOKUP to IDLE on a hit.
  - LOOKUP to WRITEBACK on a miss with a valid, dirty victim.
  - LOOKUP to REFILL on any other miss.
  - WRITEBACK to REFILL on mem_ready.
  - REFILL to RESPOND on mem_ready.
  - RESPOND to IDLE.
- REQ-029 Hit latency SHALL be done and hit in the cycle after acceptance; no memory activity.
- REQ-030 On a miss, miss SHALL pulse in the LOOKUP cycle; done SHALL pulse in RESPOND with hit=0.
- REQ-031 Victim selection SHALL take the lowest-index invalid way; otherwise the set's round-robin pointer.
- REQ-032 The round-robin pointer SHALL advance, modulo NUM_WAYS, only when a valid line is evicted.
- REQ-033 WRITEBACK SHALL hold mem_req=1 and mem_we=1, with the victim's tag/index address and line data, until mem_ready.
- REQ-034 REFILL SHALL hold mem_req=1 and mem_we=0 with the requested line address; on mem_ready the line SHALL be installed valid, clean, with the new tag.
- REQ-035 Writes SHALL be write-back/write-allocate: on completion they update the word, or only the addressed byte when byteOP=1, and set dirty.
- REQ-036 Byte reads SHALL return the addressed byte zero-extended to WORD_WIDTH.
- REQ-037 Outside WRITEBACK/REFILL, mem_req SHALL be 0.
- REQ-038 access while ready=0 SHALL be ignored.
- REQ-039 mem_ready outside WRITEBACK/REFILL SHALL be ignored.
- REQ-040 A refill completing a write SHALL merge the write data into the installed line in the same cycle.

Reset
- REQ-041 On reset, all valid and dirty bits, round-robin pointers and registered request state SHALL clear, and the FSM SHALL enter IDLE.
- REQ-042 On reset, all outputs SHALL be 0 except ready, which SHALL be 1 from the first cycle after reset.
- REQ-043 Reset asserted mid-miss SHALL abort the transfer: mem_req=0 the next cycle, no done pulse, and memory contents are not guaranteed.
- REQ-044 Line data arrays need not be reset.

Configuration
- REQ-045 With CACHE_STATS_EN defined, the block SHALL add 32-bit outputs hit_count and miss_count.
  - They increment on each hit pulse and each miss pulse, saturate at 0xFFFFFFFF, and clear on reset.
- REQ-046 Without CACHE_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Verification (defaults; memory model answers mem_ready 3 cycles after mem_req)
- REQ-047 Reset, then read 0x04 -> miss pulse; refill 0x00; done with hit=0 and data_out equal to word 1 of the model line; no writeback.
- REQ-048 Write 0x00000011 to 0x04, then word read of 0x04 -> done and hit one cycle after acceptance, data_out=0x00000011, mem_req stays 0.
- REQ-049 Byte write 0xAB to 0x06, then word read of 0x04 -> data_out=0x00AB0011; byte read of 0x06 -> 0x000000AB.
- REQ-050 After REQ-049, read 0x44, then 0x84 (all set 0) -> third access evicts way 0: WRITEBACK with mem_addr=0x00 and mem_we=1 carrying 0x00AB0011, then REFILL with mem_addr=0x80.
- REQ-051 Assert reset in the second cycle of REFILL -> mem_req=0 the next cycle, ready=1, no done; a re-read of 0x04 misses.
- REQ-052 With CACHE_STATS_EN, REQ-047 then REQ-048 -> hit_count=2, miss_count=1.
